// File: rtl/bus_master_pkg.sv
// Shared definitions for the processor-side bus master unit.
// Holds the request-kind encodings, the bus-cycle state enum, default
// widths and small decode helpers used by the FSM.
package bus_master_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned WAIT_W_DEF = 3;
  localparam int unsigned KIND_W     = 2;

  localparam logic [KIND_W-1:0] KIND_MEMR = 2'b00;
  localparam logic [KIND_W-1:0] KIND_MEMW = 2'b01;
  localparam logic [KIND_W-1:0] KIND_IOR  = 2'b10;
  localparam logic [KIND_W-1:0] KIND_IOW  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STROBE,
    RECOV,
    HOLD
  } state_t;

  // Bit 0 of the encoding distinguishes writes from reads.
  function automatic logic kind_is_write(input logic [KIND_W-1:0] kind);
    return kind[0];
  endfunction

  // One-hot strobe vector ordered {IOW, IOR, MEMW, MEMR}.
  function automatic logic [3:0] kind_strobe(input logic [KIND_W-1:0] kind);
    return 4'(4'b0001 << kind);
  endfunction

endpackage

// File: rtl/dreq_bank.sv
// Bank of DMA request latches.
// Ports: clk, reset_n; dreq_set / dreq_clr / dack per-channel pulses;
// dreq latched request per channel. A set pulse beats a same-cycle clear
// or acknowledge so a request arriving during DACK is never lost.
module dreq_bank
  import bus_master_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] dreq_set,
  input  logic [NUM_CH-1:0] dreq_clr,
  input  logic [NUM_CH-1:0] dack,
  output logic [NUM_CH-1:0] dreq
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dreq <= '0;
    end else begin
      dreq <= dreq_set | (dreq & ~(dreq_clr | dack));
    end
  end

endmodule

// File: rtl/bus_master_unit.sv
// Processor-side bus interface unit.
// Runs single MEMR/MEMW/IOR/IOW bus cycles (ADDR, STROBE with programmable
// wait states, RECOV), yields the bus to the DMA controller via HRQ/HLDA,
// and hosts the DMA request latch bank.
// Ports: core request (req_valid/ready/kind/addr/wdata, wait_cfg), response
// (rsp_valid/rsp_rdata), hold handshake (HRQ/HLDA/AEN), bus drive
// (addr_o/addr_oe, data_o/data_oe, data_i, strobes), DMA latches
// (dreq_set/dreq_clr/DREQ/DACK) and the sticky bus_err flag.
module bus_master_unit
  import bus_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned WAIT_W = WAIT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              HRQ,
  output logic              HLDA,
  input  logic              AEN,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_oe,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_i,
  output logic              MEMR,
  output logic              MEMW,
  output logic              IOR,
  output logic              IOW,
  input  logic [NUM_CH-1:0] dreq_set,
  input  logic [NUM_CH-1:0] dreq_clr,
  output logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] DACK,
  output logic              bus_err
);

  state_t              state;
  logic [KIND_W-1:0]   kind_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic [3:0]          strobe_q;
  logic                addr_oe_q;
  logic                data_oe_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                hlda_q;
  logic                bus_err_q;

  // Bus-cycle FSM; every output register is set on the edge that enters
  // the state it belongs to, so outputs line up with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      kind_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      strobe_q    <= '0;
      addr_oe_q   <= 1'b0;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      hlda_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      bus_err_q   <= bus_err_q | (AEN & ~hlda_q);
      unique case (state)
        IDLE: begin
          if (HRQ) begin
            state  <= HOLD;
            hlda_q <= 1'b1;
          end else if (req_valid) begin
            state     <= ADDR;
            kind_q    <= req_kind;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt_q     <= wait_cfg;
            addr_oe_q <= 1'b1;
            data_oe_q <= kind_is_write(req_kind);
          end
        end
        ADDR: begin
          state    <= STROBE;
          strobe_q <= kind_strobe(kind_q);
        end
        STROBE: begin
          // Counter stops at zero rather than wrapping: W+1 strobe cycles.
          if (cnt_q == '0) begin
            state       <= RECOV;
            strobe_q    <= '0;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (!kind_is_write(kind_q)) begin
              rdata_q <= data_i;
            end
          end else begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        RECOV: begin
          addr_oe_q <= 1'b0;
          if (HRQ) begin
            state  <= HOLD;
            hlda_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (!HRQ) begin
            state  <= IDLE;
            hlda_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE) & ~HRQ;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign HLDA      = hlda_q;
  assign bus_err   = bus_err_q;
  assign addr_o    = addr_q;
  assign data_o    = wdata_q;

  // While the DMA controller owns the bus nothing of ours may be driven.
  assign addr_oe = addr_oe_q & ~AEN;
  assign data_oe = data_oe_q & ~AEN;
  assign MEMR    = strobe_q[KIND_MEMR] & ~AEN;
  assign MEMW    = strobe_q[KIND_MEMW] & ~AEN;
  assign IOR     = strobe_q[KIND_IOR]  & ~AEN;
  assign IOW     = strobe_q[KIND_IOW]  & ~AEN;

  dreq_bank #(
    .NUM_CH(NUM_CH)
  ) u_dreq_bank (
    .clk      (clk),
    .reset_n  (reset_n),
    .dreq_set (dreq_set),
    .dreq_clr (dreq_clr),
    .dack     (DACK),
    .dreq     (DREQ)
  );

endmodule

// File: tb/tb_bus_master_unit.sv
// Scoreboard bench for bus_master_unit: requests push expected responses,
// a negedge monitor checks strobes, enables, latency and read data.
`timescale 1ns/1ps
module tb_bus_master_unit;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WAIT_W = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_kind = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic [WAIT_W-1:0] wait_cfg = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              HRQ = 1'b0;
  logic              HLDA;
  logic              AEN = 1'b0;
  logic [ADDR_W-1:0] addr_o;
  logic              addr_oe;
  logic [DATA_W-1:0] data_o;
  logic              data_oe;
  logic [DATA_W-1:0] data_i = '0;
  logic              MEMR, MEMW, IOR, IOW;
  logic [NUM_CH-1:0] dreq_set = '0;
  logic [NUM_CH-1:0] dreq_clr = '0;
  logic [NUM_CH-1:0] DREQ;
  logic [NUM_CH-1:0] DACK = '0;
  logic              bus_err;

  always #5 clk = ~clk;

  bus_master_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .WAIT_W(WAIT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_addr(req_addr), .req_wdata(req_wdata), .wait_cfg(wait_cfg),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .HRQ(HRQ), .HLDA(HLDA), .AEN(AEN),
    .addr_o(addr_o), .addr_oe(addr_oe), .data_o(data_o), .data_oe(data_oe),
    .data_i(data_i), .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW),
    .dreq_set(dreq_set), .dreq_clr(dreq_clr), .DREQ(DREQ), .DACK(DACK),
    .bus_err(bus_err)
  );

  typedef struct {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int unsigned       w;
    logic [DATA_W-1:0] rdata;
    int unsigned       due;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  int unsigned cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference rules: writes are MEMW/IOW; strobe index follows the kind code.
  function automatic bit model_is_write(input logic [1:0] k);
    return (k == 2'b01) || (k == 2'b11);
  endfunction

  function automatic logic [NUM_CH-1:0] model_dreq(input logic [NUM_CH-1:0] cur,
      input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] c, input logic [NUM_CH-1:0] a);
    logic [NUM_CH-1:0] n;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (s[i])              n[i] = 1'b1;
      else if (c[i] || a[i]) n[i] = 1'b0;
      else                   n[i] = cur[i];
    end
    return n;
  endfunction

  // Monitor: accumulates strobe / data_oe activity of the in-flight request.
  int unsigned stb_cnt[4];
  int unsigned doe_cnt;
  logic [3:0]  mon_s;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) stb_cnt[k] = 0;
      doe_cnt = 0;
    end else begin
      mon_s = {IOW, IOR, MEMW, MEMR};
      if (mon_s != 4'b0000) check("strobe_onehot", 64'($countones(mon_s)), 64'd1);
      for (int k = 0; k < 4; k++) if (mon_s[k]) stb_cnt[k]++;
      if (data_oe) doe_cnt++;
      if (addr_oe) begin
        if (sb.size() == 0) check("addr_oe_idle", 64'(addr_oe), 64'd0);
        else                check("addr_o", 64'(addr_o), 64'(sb[0].addr));
        if (data_oe && sb.size() != 0) check("data_o", 64'(data_o), 64'(sb[0].wdata));
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_latency", 64'(cyc), 64'(mon_e.due));
          if (!model_is_write(mon_e.kind))
            check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
          check("strobe_cycles", 64'(stb_cnt[mon_e.kind]), 64'(mon_e.w + 1));
          check("strobe_total", 64'(stb_cnt[0] + stb_cnt[1] + stb_cnt[2] + stb_cnt[3]),
                64'(mon_e.w + 1));
          check("data_oe_cycles", 64'(doe_cnt),
                model_is_write(mon_e.kind) ? 64'(mon_e.w + 2) : 64'd0);
        end
        for (int k = 0; k < 4; k++) stb_cnt[k] = 0;
        doe_cnt = 0;
      end
    end
  end

  // Inputs change 2ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [1:0] k, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] wd, input int unsigned w,
                       input logic [DATA_W-1:0] rd);
    exp_t e;
    int   guard;
    req_valid = 1'b1; req_kind = k; req_addr = a; req_wdata = wd;
    wait_cfg = WAIT_W'(w); data_i = rd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.kind = k; e.addr = a; e.wdata = wd; e.w = w; e.rdata = rd;
    e.due = cyc + 1 + w + 2;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    req_addr  = ADDR_W'($urandom);
    req_wdata = DATA_W'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    if (sb.size() != 0) begin
      check("rsp_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [NUM_CH-1:0] dm;
  logic [NUM_CH-1:0] rs, rc, ra;

  initial begin
    // Reset state
    #12;
    check("rst_addr_oe", 64'(addr_oe), 64'd0);
    check("rst_data_oe", 64'(data_oe), 64'd0);
    check("rst_strobes", 64'({MEMR, MEMW, IOR, IOW}), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_hlda", 64'(HLDA), 64'd0);
    check("rst_dreq", 64'(DREQ), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_req_ready", 64'(req_ready), 64'd1);

    // Directed transactions
    issue(2'b00, 16'h1234, 8'h00, 0, 8'hA5);
    wait_idle();
    issue(2'b11, 16'h0040, 8'h3C, 3, 8'h00);
    wait_idle();

    // Random transactions, first with the maximum wait count
    for (int i = 0; i < 24; i++) begin
      issue(2'($urandom_range(0, 3)), ADDR_W'($urandom), DATA_W'($urandom),
            (i == 0) ? 7 : $urandom_range(0, 7), DATA_W'($urandom));
      wait_idle();
      if ($urandom_range(0, 1) == 1) tick();
    end

    // HRQ in the second STROBE cycle of a W=2 read is deferred
    issue(2'b10, 16'hBEEF, 8'h00, 2, 8'h5A);
    tick();
    tick();
    HRQ = 1'b1;
    wait_idle();
    check("hold_hlda", 64'(HLDA), 64'd1);
    check("hold_addr_oe", 64'(addr_oe), 64'd0);
    check("hold_data_oe", 64'(data_oe), 64'd0);
    check("hold_req_ready", 64'(req_ready), 64'd0);
    HRQ = 1'b0;
    tick();
    check("release_hlda", 64'(HLDA), 64'd0);
    check("release_req_ready", 64'(req_ready), 64'd1);

    // HRQ and req_valid together in IDLE: hold wins
    HRQ = 1'b1; req_valid = 1'b1; req_kind = 2'b01; req_addr = 16'h7777;
    tick();
    check("prio_hlda", 64'(HLDA), 64'd1);
    check("prio_req_ready", 64'(req_ready), 64'd0);
    tick();
    check("prio_addr_oe", 64'(addr_oe), 64'd0);
    HRQ = 1'b0;
    issue(2'b01, 16'h7777, 8'h99, 1, 8'h00);
    wait_idle();

    // DMA request latches
    dm = '0;
    dreq_set = 4'b0101;
    tick();
    dreq_set = '0;
    check("dreq_set", 64'(DREQ), 64'h5);
    dreq_set = 4'b0100; DACK = 4'b0100;
    tick();
    dreq_set = '0; DACK = '0;
    check("dreq_set_wins", 64'(DREQ), 64'h5);
    DACK = 4'b0001;
    tick();
    DACK = '0;
    check("dreq_dack", 64'(DREQ), 64'h4);
    dm = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      rs = NUM_CH'($urandom & $urandom);
      rc = NUM_CH'($urandom & $urandom);
      ra = NUM_CH'($urandom & $urandom);
      dreq_set = rs; dreq_clr = rc; DACK = ra;
      dm = model_dreq(dm, rs, rc, ra);
      tick();
      check("dreq_rand", 64'(DREQ), 64'(dm));
    end
    dreq_set = 4'b1111; dreq_clr = '0; DACK = '0;
    tick();
    dreq_set = '0;

    // Reset in the middle of a MEMW strobe
    issue(2'b01, 16'hA0A0, 8'h42, 3, 8'h00);
    tick();
    check("pre_reset_memw", 64'(MEMW), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_memw", 64'(MEMW), 64'd0);
    check("mid_rst_addr_oe", 64'(addr_oe), 64'd0);
    check("mid_rst_data_oe", 64'(data_oe), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_dreq", 64'(DREQ), 64'd0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    issue(2'b00, 16'h0001, 8'h00, 1, 8'hC3);
    wait_idle();

    // Sticky bus error
    check("bus_err_clear", 64'(bus_err), 64'd0);
    AEN = 1'b1;
    tick();
    check("bus_err_set", 64'(bus_err), 64'd1);
    AEN = 1'b0;
    tick();
    tick();
    check("bus_err_sticky", 64'(bus_err), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
